// File: rtl/gumnut_sequencer.sv
// Gumnut instruction-cycle sequencer. It runs the fetch/decode/execute/write-back
// cycle, the bus handshakes with ack timeout, and interrupt entry and exit.
module gumnut_sequencer #(
    parameter int          TIMEOUT = 16,
    parameter logic [11:0] INT_VEC = 12'h001
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [2:0] op_e,
    input  logic [2:0] func_e,
    input  logic       carry_e,
    input  logic       zero_e,
    output logic       inst_cyc_o,
    output logic       inst_stb_o,
    input  logic       inst_ack_i,
    output logic       data_cyc_o,
    output logic       data_stb_o,
    output logic       data_we_o,
    input  logic       data_ack_i,
    output logic       port_cyc_o,
    output logic       port_stb_o,
    output logic       port_we_o,
    input  logic       port_ack_i,
    input  logic       int_req_i,
    output logic       int_ack_o,
    output logic       ir_load_c,
    output logic       RegWrt_c,
    output logic [1:0] RegMux_c,
    output logic       op2_c,
    output logic [3:0] ALUOp_c,
    output logic       cc_wrt_c,
    output logic       pc_inc_c,
    output logic       pc_ld_c,
    output logic [1:0] pc_src_c,
    output logic       stack_push_c,
    output logic       stack_pop_c,
    output logic       int_en_o,
    output logic       standby_o,
    output logic       bus_err_o
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        RESET, FETCH, DECODE, EXECUTE, MEM, WRITE_BACK, INT, HALT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [2:0]    func_q, func_d;
    logic          int_en_q, int_en_d;
    logic          retry_q, retry_d;
    logic [CW-1:0] tmo_q, tmo_d;

    logic   fetch_ack, mem_ack, waiting, tmo_hit, int_take, br_taken, is_alu;
    state_t chk_state;

    // The vector itself is applied by the datapath PC mux when pc_src_c == 2'b11.
    logic unused_int_vec;
    assign unused_int_vec = ^INT_VEC;

    assign fetch_ack = (state_q == FETCH) && !retry_q && inst_ack_i;
    assign mem_ack   = (state_q == MEM) && (func_q[1] ? port_ack_i : data_ack_i);
    assign waiting   = ((state_q == FETCH) && !retry_q && !inst_ack_i) ||
                       ((state_q == MEM) && !mem_ack);
    assign tmo_hit   = (TIMEOUT != 0) && waiting && (int'(tmo_q) == TIMEOUT - 1);
    assign int_take  = int_req_i && int_en_q;
    assign chk_state = int_take ? INT : FETCH;
    assign is_alu    = (op_q == 3'b000) || (op_q == 3'b001) || (op_q == 3'b010);
    assign int_en_o  = int_en_q;

    always_comb begin
        case (func_q[1:0])
            2'b00:   br_taken = zero_e;
            2'b01:   br_taken = !zero_e;
            2'b10:   br_taken = carry_e;
            default: br_taken = !carry_e;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        func_d   = func_q;
        int_en_d = int_en_q;
        retry_d  = 1'b0;
        tmo_d    = tmo_q;
        case (state_q)
            RESET: state_d = FETCH;
            FETCH: begin
                // A timed-out fetch idles one cycle with strobes low, then retries.
                if (fetch_ack)    state_d = DECODE;
                else if (tmo_hit) retry_d = 1'b1;
            end
            DECODE: begin
                op_d    = op_e;
                func_d  = func_e;
                state_d = EXECUTE;
            end
            EXECUTE: begin
                case (op_q)
                    3'b000, 3'b001, 3'b010: state_d = WRITE_BACK;
                    3'b011:                 state_d = MEM;
                    3'b110: begin
                        state_d = chk_state;
                        case (func_q)
                            3'b001, 3'b010: int_en_d = 1'b1;
                            3'b011:         int_en_d = 1'b0;
                            3'b100, 3'b101: state_d  = HALT;
                            default:        ;
                        endcase
                    end
                    default: state_d = chk_state;
                endcase
            end
            MEM: begin
                if (mem_ack)      state_d = func_q[0] ? chk_state : WRITE_BACK;
                else if (tmo_hit) state_d = chk_state;
            end
            WRITE_BACK: state_d = chk_state;
            INT: begin
                int_en_d = 1'b0;
                state_d  = FETCH;
            end
            HALT: if (int_take) state_d = INT;
            default: state_d = RESET;
        endcase
        if ((TIMEOUT == 0) || (state_d != state_q) || tmo_hit) tmo_d = '0;
        else if (waiting)                                     tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= RESET;
            op_q     <= '0;
            func_q   <= '0;
            int_en_q <= 1'b0;
            retry_q  <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            func_q   <= func_d;
            int_en_q <= int_en_d;
            retry_q  <= retry_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        inst_cyc_o   = 1'b0;
        inst_stb_o   = 1'b0;
        data_cyc_o   = 1'b0;
        data_stb_o   = 1'b0;
        data_we_o    = 1'b0;
        port_cyc_o   = 1'b0;
        port_stb_o   = 1'b0;
        port_we_o    = 1'b0;
        int_ack_o    = 1'b0;
        ir_load_c    = 1'b0;
        RegWrt_c     = 1'b0;
        RegMux_c     = 2'b00;
        op2_c        = 1'b0;
        ALUOp_c      = 4'h0;
        cc_wrt_c     = 1'b0;
        pc_inc_c     = 1'b0;
        pc_ld_c      = 1'b0;
        pc_src_c     = 2'b00;
        stack_push_c = 1'b0;
        stack_pop_c  = 1'b0;
        standby_o    = 1'b0;
        bus_err_o    = 1'b0;
        case (state_q)
            FETCH: begin
                inst_cyc_o = !retry_q;
                inst_stb_o = !retry_q;
                ir_load_c  = fetch_ack;
                pc_inc_c   = fetch_ack;
                bus_err_o  = tmo_hit;
            end
            EXECUTE: begin
                if (is_alu) begin
                    ALUOp_c = {op_q == 3'b010, func_q};
                    op2_c   = (op_q == 3'b001);
                end
                case (op_q)
                    3'b100: pc_ld_c = br_taken;
                    3'b101: begin
                        pc_ld_c      = 1'b1;
                        pc_src_c     = 2'b01;
                        stack_push_c = func_q[0];
                    end
                    3'b110: begin
                        if (func_q == 3'b000 || func_q == 3'b001) begin
                            stack_pop_c = 1'b1;
                            pc_ld_c     = 1'b1;
                            pc_src_c    = 2'b10;
                            cc_wrt_c    = func_q[0];
                        end
                    end
                    default: ;
                endcase
            end
            MEM: begin
                data_cyc_o = !func_q[1];
                data_stb_o = !func_q[1];
                data_we_o  = !func_q[1] && func_q[0];
                port_cyc_o = func_q[1];
                port_stb_o = func_q[1];
                port_we_o  = func_q[1] && func_q[0];
                bus_err_o  = tmo_hit;
            end
            WRITE_BACK: begin
                RegWrt_c = 1'b1;
                if (is_alu) begin
                    ALUOp_c  = {op_q == 3'b010, func_q};
                    op2_c    = (op_q == 3'b001);
                    cc_wrt_c = 1'b1;
                end else begin
                    RegMux_c = func_q[1] ? 2'b10 : 2'b01;
                end
            end
            INT: begin
                int_ack_o    = 1'b1;
                stack_push_c = 1'b1;
                pc_ld_c      = 1'b1;
                pc_src_c     = 2'b11;
            end
            HALT: standby_o = (func_q == 3'b101);
            default: ;
        endcase
    end
endmodule
